// File: rtl/avmm_lvds_bridge_pkg.sv
// Shared types for the Avalon-MM LVDS bridge: address width, burst count type,
// host arbiter FSM states and the read-ID FIFO entry.
package avmm_lvds_bridge_pkg;

    localparam int unsigned ADDR_W    = 24;
    localparam int unsigned MAX_BURST = 16;
    localparam int unsigned BURST_W   = $clog2(MAX_BURST) + 1;
    // Wide enough for the largest supported host count (8).
    localparam int unsigned HOST_ID_W = 3;

    typedef logic [BURST_W-1:0]   burstcnt_t;
    typedef logic [HOST_ID_W-1:0] host_id_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        WBURST = 2'd2
    } arb_state_e;

    // One in-flight read: who issued it and how many beats it still owes.
    typedef struct packed {
        host_id_t  id;
        burstcnt_t beats;
    } id_entry_t;

    // A burstcount of zero behaves as a single beat.
    function automatic burstcnt_t norm_burst(input burstcnt_t bc);
        return (bc == '0) ? burstcnt_t'(1) : bc;
    endfunction

endpackage

// File: rtl/avmm_arb_id_fifo.sv
// Synchronous FIFO holding {host id, beat count} for each outstanding read.
// DEPTH must be a power of two and at least 2.
module avmm_arb_id_fifo
    import avmm_lvds_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  id_entry_t i_wdata,
    input  logic      i_pop,
    output id_entry_t o_rdata,
    output logic      o_full,
    output logic      o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    id_entry_t        r_mem [DEPTH];
    logic [PTR_W:0]   r_wptr;
    logic [PTR_W:0]   r_rptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Extra pointer MSB distinguishes full from empty.
    always_comb begin
        o_empty   = (r_wptr == r_rptr);
        o_full    = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                    (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
        w_pop_ok  = i_pop && !o_empty;
        w_push_ok = i_push && (!o_full || w_pop_ok);
        o_rdata   = r_mem[r_rptr[PTR_W-1:0]];
    end

    // Pointer update; push and pop together leave occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care while empty so no reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr[PTR_W-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/avmm_host_arbiter.sv
// Avalon-MM arbiter: N_HOSTS hosts share one bridge port. Grants are
// registered, write bursts lock the grant, and read responses are routed
// back through an in-order ID FIFO.
// Define AVMM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
// otherwise arbitration is round-robin after the last-granted host.
module avmm_host_arbiter
    import avmm_lvds_bridge_pkg::*;
#(
    parameter int unsigned N_HOSTS     = 2,
    parameter int unsigned OUTST_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_HOSTS-1:0][ADDR_W-1:0]  h_address,
    input  logic [N_HOSTS-1:0]              h_read,
    input  logic [N_HOSTS-1:0]              h_write,
    input  burstcnt_t [N_HOSTS-1:0]         h_burstcount,
    input  logic [N_HOSTS-1:0][3:0]         h_byteenable,
    input  logic [N_HOSTS-1:0][31:0]        h_writedata,
    output logic [N_HOSTS-1:0]              h_waitrequest,
    output logic [31:0]                     h_readdata,
    output logic [N_HOSTS-1:0]              h_readdatavalid,
    output logic [ADDR_W-1:0]               m_address,
    output logic                            m_read,
    output logic                            m_write,
    output burstcnt_t                       m_burstcount,
    output logic [3:0]                      m_byteenable,
    output logic [31:0]                     m_writedata,
    input  logic                            m_waitrequest,
    input  logic [31:0]                     m_readdata,
    input  logic                            m_readdatavalid,
    output logic                            err_orphan
);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    host_id_t            r_grant;
    host_id_t            w_grant_nxt;
    burstcnt_t           r_beat_cnt;
    burstcnt_t           w_beat_cnt_nxt;
    burstcnt_t           r_head_done;
    logic                r_err_orphan;

    logic [N_HOSTS-1:0]  w_req;
    logic                w_any_req;
    host_id_t            w_winner;

    logic [ADDR_W-1:0]   w_g_address;
    logic                w_g_read;
    logic                w_g_write;
    burstcnt_t           w_g_burstcount;
    burstcnt_t           w_g_beats;
    logic [3:0]          w_g_byteenable;
    logic [31:0]         w_g_writedata;

    logic                w_active;
    logic                w_rd_acc;
    logic                w_wr_acc;

    logic                w_fifo_full;
    logic                w_fifo_empty;
    id_entry_t           w_fifo_wdata;
    id_entry_t           w_head;
    logic                w_rsp_hit;
    logic                w_pop;

    // Eligible requesters: reads only while the ID FIFO has room.
    always_comb begin
        w_req     = h_write | (h_read & {N_HOSTS{!w_fifo_full}});
        w_any_req = |w_req;
    end

`ifdef AVMM_ARB_FIXED_PRIO_EN
    // Fixed priority: scan downwards so the lowest requesting index wins.
    always_comb begin
        w_winner = '0;
        for (int i = int'(N_HOSTS) - 1; i >= 0; i--) begin
            if (w_req[i]) w_winner = host_id_t'(i);
        end
    end
`else
    host_id_t   r_rr_ptr;
    logic [3:0] w_dist;
    logic [3:0] w_best;

    // Round-robin: pick the requester closest after the last-granted host.
    always_comb begin
        w_winner = '0;
        w_best   = 4'hF;
        w_dist   = '0;
        for (int i = 0; i < int'(N_HOSTS); i++) begin
            w_dist = 4'((i + int'(N_HOSTS) - 1 - int'(r_rr_ptr)) % int'(N_HOSTS));
            if (w_req[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_winner = host_id_t'(i);
            end
        end
    end

    // Last-granted pointer; reset value makes host 0 the first choice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= host_id_t'(N_HOSTS - 1);
        end else if ((r_state == IDLE) && w_any_req) begin
            r_rr_ptr <= w_winner;
        end
    end
`endif

    // Mux the granted host's command onto internal wires.
    always_comb begin
        w_g_address    = '0;
        w_g_read       = 1'b0;
        w_g_write      = 1'b0;
        w_g_burstcount = '0;
        w_g_byteenable = '0;
        w_g_writedata  = '0;
        for (int i = 0; i < int'(N_HOSTS); i++) begin
            if (r_grant == host_id_t'(i)) begin
                w_g_address    = h_address[i];
                w_g_read       = h_read[i];
                w_g_write      = h_write[i];
                w_g_burstcount = h_burstcount[i];
                w_g_byteenable = h_byteenable[i];
                w_g_writedata  = h_writedata[i];
            end
        end
        w_g_beats = norm_burst(w_g_burstcount);
    end

    // Bridge-side command and per-host stall; reads never issue mid write burst.
    always_comb begin
        w_active      = (r_state == CMD) || (r_state == WBURST);
        m_address     = w_g_address;
        m_burstcount  = w_g_burstcount;
        m_byteenable  = w_g_byteenable;
        m_writedata   = w_g_writedata;
        m_read        = (r_state == CMD) && w_g_read;
        m_write       = w_active && w_g_write;
        w_rd_acc      = m_read && !m_waitrequest;
        w_wr_acc      = m_write && !m_waitrequest;
        h_waitrequest = '1;
        for (int i = 0; i < int'(N_HOSTS); i++) begin
            if (w_active && (r_grant == host_id_t'(i))) h_waitrequest[i] = m_waitrequest;
        end
    end

    // Arbiter FSM next-state.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_beat_cnt_nxt = r_beat_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = CMD;
                    w_grant_nxt = w_winner;
                end
            end
            CMD: begin
                if (w_rd_acc) begin
                    w_state_nxt = IDLE;
                end else if (w_wr_acc) begin
                    if (w_g_beats > burstcnt_t'(1)) begin
                        w_state_nxt    = WBURST;
                        w_beat_cnt_nxt = w_g_beats - burstcnt_t'(1);
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (!w_g_read && !w_g_write) begin
                    // Host withdrew its request; free the port.
                    w_state_nxt = IDLE;
                end
            end
            WBURST: begin
                if (w_wr_acc) begin
                    w_beat_cnt_nxt = r_beat_cnt - burstcnt_t'(1);
                    if (r_beat_cnt == burstcnt_t'(1)) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM, grant and write-burst counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    assign w_fifo_wdata = '{id: r_grant, beats: w_g_beats};

    avmm_arb_id_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rd_acc),
        .i_wdata (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Route response beats to the host at the FIFO head; pop on its last beat.
    always_comb begin
        w_rsp_hit  = m_readdatavalid && !w_fifo_empty;
        w_pop      = w_rsp_hit && ((r_head_done + burstcnt_t'(1)) == w_head.beats);
        h_readdata = m_readdata;
        for (int i = 0; i < int'(N_HOSTS); i++) begin
            h_readdatavalid[i] = w_rsp_hit && (w_head.id == host_id_t'(i));
        end
        err_orphan = r_err_orphan;
    end

    // Beats delivered for the head read, and the sticky orphan flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_done  <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_pop) begin
                r_head_done <= '0;
            end else if (w_rsp_hit) begin
                r_head_done <= r_head_done + burstcnt_t'(1);
            end
            if (m_readdatavalid && w_fifo_empty) r_err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_avmm_host_arbiter.sv
// Randomized bench for avmm_host_arbiter: host queues drive commands, the
// bridge side is checked against each host's queued beats, and read data is
// checked against an in-order list of expected response beats.
module tb_avmm_host_arbiter;
    import avmm_lvds_bridge_pkg::*;

    localparam int N_H   = 2;
    localparam int DEPTH = 8;

    typedef struct {
        bit                rd;
        bit                last;
        logic [ADDR_W-1:0] addr;
        burstcnt_t         bc;
        logic [3:0]        be;
        logic [31:0]       wd;
    } beat_t;

    typedef struct {
        int host;
        bit last;
    } rsp_t;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [N_H-1:0][ADDR_W-1:0]   h_address;
    logic [N_H-1:0]               h_read;
    logic [N_H-1:0]               h_write;
    burstcnt_t [N_H-1:0]          h_burstcount;
    logic [N_H-1:0][3:0]          h_byteenable;
    logic [N_H-1:0][31:0]         h_writedata;
    logic [N_H-1:0]               h_waitrequest;
    logic [31:0]                  h_readdata;
    logic [N_H-1:0]               h_readdatavalid;
    logic [ADDR_W-1:0]            m_address;
    logic                         m_read;
    logic                         m_write;
    burstcnt_t                    m_burstcount;
    logic [3:0]                   m_byteenable;
    logic [31:0]                  m_writedata;
    logic                         m_waitrequest;
    logic [31:0]                  m_readdata;
    logic                         m_readdatavalid;
    logic                         err_orphan;

    beat_t drv_q [N_H][$];
    rsp_t  rsp_q [$];
    int    acc_log [$];
    int    rdv_log [$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    outstanding = 0;
    int    lock_host = -1;
    int    lock_left = 0;
    bit    wait_rand = 1'b0;
    bit    rsp_en = 1'b1;
    bit    inject_orphan = 1'b0;

    avmm_host_arbiter #(
        .N_HOSTS     (N_H),
        .OUTST_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .h_address       (h_address),
        .h_read          (h_read),
        .h_write         (h_write),
        .h_burstcount    (h_burstcount),
        .h_byteenable    (h_byteenable),
        .h_writedata     (h_writedata),
        .h_waitrequest   (h_waitrequest),
        .h_readdata      (h_readdata),
        .h_readdatavalid (h_readdatavalid),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_burstcount    (m_burstcount),
        .m_byteenable    (m_byteenable),
        .m_writedata     (m_writedata),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .err_orphan      (err_orphan)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int beats_of(input burstcnt_t bc);
        return (bc == '0) ? 1 : int'(bc);
    endfunction

    // Queue one command for host h; the host id is encoded in the address MSBs.
    task automatic issue(input int h, input bit rd, input int bc);
        beat_t b;
        int    nb;
        b.rd   = rd;
        b.bc   = burstcnt_t'(bc);
        b.addr = {4'(h), 20'($urandom)};
        b.be   = 4'($urandom);
        nb     = rd ? 1 : beats_of(b.bc);
        for (int i = 0; i < nb; i++) begin
            b.wd   = rd ? 32'h0 : $urandom;
            b.last = (i == nb - 1);
            drv_q[h].push_back(b);
        end
    endtask

    task automatic drive();
        m_waitrequest   = wait_rand ? ($urandom_range(0, 99) < 30) : 1'b0;
        m_readdata      = $urandom;
        m_readdatavalid = inject_orphan ||
                          (rsp_en && (rsp_q.size() > 0) && ($urandom_range(0, 99) < 60));
        for (int h = 0; h < N_H; h++) begin
            if (drv_q[h].size() > 0) begin
                h_read[h]       = drv_q[h][0].rd;
                h_write[h]      = !drv_q[h][0].rd;
                h_address[h]    = drv_q[h][0].addr;
                h_burstcount[h] = drv_q[h][0].bc;
                h_byteenable[h] = drv_q[h][0].be;
                h_writedata[h]  = drv_q[h][0].wd;
            end else begin
                h_read[h]       = 1'b0;
                h_write[h]      = 1'b0;
                h_address[h]    = '0;
                h_burstcount[h] = '0;
                h_byteenable[h] = '0;
                h_writedata[h]  = '0;
            end
        end
    endtask

    task automatic sample();
        int    acc;
        int    nb;
        bit    ok;
        beat_t b;
        rsp_t  r;
        acc = -1;
        if ((m_read || m_write) && !m_waitrequest) begin
            acc = int'(m_address[ADDR_W-1 -: 4]);
            ok  = 1'b0;
            if (acc < N_H) ok = (drv_q[acc].size() > 0);
            check_eq("cmd_source", 96'(ok), 96'(1));
            if (ok) begin
                b = drv_q[acc][0];
                acc_log.push_back(acc);
                check_eq("cmd_fields",
                         96'({m_read, m_write, m_address, m_burstcount, m_byteenable, m_writedata}),
                         96'({b.rd, !b.rd, b.addr, b.bc, b.be, b.wd}));
                if (lock_left > 0) begin
                    check_eq("burst_lock", 96'(acc), 96'(lock_host));
                    lock_left--;
                end else if (!b.rd && beats_of(b.bc) > 1) begin
                    lock_host = acc;
                    lock_left = beats_of(b.bc) - 1;
                end
                if (b.rd) begin
                    check_eq("outst_limit", 96'(outstanding < DEPTH), 96'(1));
                    outstanding++;
                    nb = beats_of(b.bc);
                    for (int i = 0; i < nb; i++) rsp_q.push_back('{host: acc, last: (i == nb - 1)});
                end
            end
        end
        for (int h = 0; h < N_H; h++) begin
            if (drv_q[h].size() > 0) begin
                check_eq("h_waitreq", 96'(h_waitrequest[h]), 96'(acc != h));
                if (!h_waitrequest[h]) void'(drv_q[h].pop_front());
            end
        end
        if (m_readdatavalid) begin
            if (rsp_q.size() > 0) begin
                r = rsp_q.pop_front();
                check_eq("rdv_route", 96'(h_readdatavalid), 96'(1 << r.host));
                check_eq("rdata", 96'(h_readdata), 96'(m_readdata));
                rdv_log.push_back(r.host);
                if (r.last) outstanding--;
            end else begin
                check_eq("orphan_drop", 96'(h_readdatavalid), 96'(0));
            end
        end else begin
            check_eq("rdv_idle", 96'(h_readdatavalid), 96'(0));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    function automatic bit busy();
        bit b;
        b = (rsp_q.size() > 0);
        for (int h = 0; h < N_H; h++) if (drv_q[h].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input string tag, input int max);
        int n;
        n = 0;
        while (busy() && n < max) begin
            step();
            n++;
        end
        check_eq(tag, 96'(busy()), 96'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_waitreq"}, 96'(h_waitrequest), 96'({N_H{1'b1}}));
        check_eq({tag, "_mcmd"}, 96'({m_read, m_write}), 96'(0));
        check_eq({tag, "_rdv"}, 96'(h_readdatavalid), 96'(0));
        check_eq({tag, "_orphan"}, 96'(err_orphan), 96'(0));
    endtask

    initial begin
        int n;
        h_read = '0; h_write = '0; h_address = '0; h_burstcount = '0;
        h_byteenable = '0; h_writedata = '0;
        m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Two hosts with back-to-back single writes alternate 0,1,0,1...
        for (int i = 0; i < 3; i++) begin
            issue(0, 1'b0, 1);
            issue(1, 1'b0, 1);
        end
        acc_log.delete();
        drain("rr_drain", 200);
        check_eq("rr_count", 96'(acc_log.size()), 96'(6));
        foreach (acc_log[i]) check_eq("rr_order", 96'(acc_log[i]), 96'(i % 2));

        // A 16-beat burst from host 0 holds off host 1 until its last beat.
        wait_rand = 1'b1;
        acc_log.delete();
        issue(0, 1'b0, 16);
        issue(1, 1'b0, 1);
        drain("burst_drain", 400);
        check_eq("burst_count", 96'(acc_log.size()), 96'(17));
        foreach (acc_log[i]) check_eq("burst_order", 96'(acc_log[i]), 96'((i < 16) ? 0 : 1));

        // Host 1 reads 4 beats, then host 0 reads 1; data comes back in that order.
        wait_rand = 1'b0;
        rdv_log.delete();
        issue(1, 1'b1, 4);
        repeat (3) step();
        issue(0, 1'b1, 1);
        drain("rd_drain", 400);
        check_eq("rd_beats", 96'(rdv_log.size()), 96'(5));
        foreach (rdv_log[i]) check_eq("rd_route_order", 96'(rdv_log[i]), 96'((i < 4) ? 1 : 0));

        // Eight reads fill the ID FIFO; a ninth stalls while a write still gets through.
        rsp_en = 1'b0;
        for (int i = 0; i < 9; i++) issue(0, 1'b1, $urandom_range(1, 2));
        n = 0;
        while (outstanding < DEPTH && n < 200) begin
            step();
            n++;
        end
        check_eq("fifo_fill", 96'(outstanding), 96'(DEPTH));
        repeat (10) step();
        check_eq("full_holds_read", 96'(drv_q[0].size()), 96'(1));
        check_eq("full_waitreq", 96'(h_waitrequest[0]), 96'(1));
        issue(1, 1'b0, 2);
        n = 0;
        while (drv_q[1].size() > 0 && n < 50) begin
            step();
            n++;
        end
        check_eq("write_while_full", 96'(drv_q[1].size()), 96'(0));
        check_eq("read_still_held", 96'(drv_q[0].size()), 96'(1));
        rsp_en = 1'b1;
        drain("full_drain", 400);
        check_eq("full_outst_end", 96'(outstanding), 96'(0));
        check_eq("orphan_clear", 96'(err_orphan), 96'(0));

        // Response with nothing outstanding: dropped, flag sticks.
        inject_orphan = 1'b1;
        step();
        inject_orphan = 1'b0;
        step();
        check_eq("orphan_set", 96'(err_orphan), 96'(1));
        repeat (5) step();
        check_eq("orphan_sticky", 96'(err_orphan), 96'(1));

        // Reset in the middle of a burst with a read outstanding.
        rsp_en = 1'b0;
        acc_log.delete();
        issue(1, 1'b1, 4);
        issue(0, 1'b0, 16);
        n = 0;
        while (acc_log.size() < 7 && n < 200) begin
            step();
            n++;
        end
        check_eq("midburst_reached", 96'(acc_log.size() >= 7), 96'(1));
        @(posedge clk);
        #1;
        m_readdatavalid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midburst_rst");
        for (int h = 0; h < N_H; h++) drv_q[h].delete();
        rsp_q.delete();
        outstanding = 0;
        lock_left = 0;
        lock_host = -1;
        drive();
        m_readdatavalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic, random stalls and random response timing.
        wait_rand = 1'b1;
        rsp_en = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            for (int h = 0; h < N_H; h++) begin
                if (drv_q[h].size() == 0 && $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 1) issue(h, 1'b1, $urandom_range(0, 8));
                    else issue(h, 1'b0, $urandom_range(0, 16));
                end
            end
            step();
        end
        drain("rand_drain", 3000);
        check_eq("rand_outst_end", 96'(outstanding), 96'(0));
        check_eq("rand_no_orphan", 96'(err_orphan), 96'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/avmm_host_arbiter.md
AVMM_HOST_ARBITER -- requirements
Module: avmm_host_arbiter

Interface
REQ-001 Parameter N_HOSTS, default 2: number of Avalon-MM hosts sharing one bridge port (2..8).
REQ-002 Parameter OUTST_DEPTH, default 8: maximum in-flight read commands (power of 2).
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 h_address  in  N_HOSTS x ADDR_W  per-host word address.
REQ-006 h_read / h_write  in  N_HOSTS each  per-host command strobes.
REQ-007 h_burstcount  in  N_HOSTS x burstcnt_t  per-host beat count.
REQ-008 h_byteenable  in  N_HOSTS x 4  per-host byte enables.
REQ-009 h_writedata  in  N_HOSTS x 32  per-host write data.
REQ-010 h_waitrequest  out  N_HOSTS  per-host stall.
REQ-011 h_readdata  out  32  read data broadcast to all hosts.
REQ-012 h_readdatavalid  out  N_HOSTS  per-host read-data strobe.
REQ-013 m_address, m_read, m_write, m_burstcount, m_byteenable, m_writedata  out  (same widths)  bridge-side command.
REQ-014 m_waitrequest  in  1;  m_readdata  in  32;  m_readdatavalid  in  1  bridge-side handshake and response.
REQ-015 err_orphan  out  1  sticky flag: read data arrived with no outstanding read.

Function
REQ-016 FSM states: IDLE, CMD, WBURST; the grant is registered, so a request sampled in cycle N drives m_* in cycle N+1.
REQ-017 IDLE: if any h_read/h_write is asserted, grant the next requester in round-robin order after the last-granted host, then go to CMD.
REQ-018 CMD: m_* mirrors the granted host; h_waitrequest[g] = m_waitrequest; all other h_waitrequest stay high.
REQ-019 Read accepted (m_read && !m_waitrequest): push {host id, burstcount} into the ID FIFO, then return to IDLE.
REQ-020 Write beat accepted with burstcount > 1: load beat counter = burstcount-1 and go to WBURST; with burstcount = 1, return to IDLE.
REQ-021 WBURST: grant is locked; decrement the counter on each accepted beat; return to IDLE when the counter reaches 0 on an accepted beat.
REQ-022 burstcount = 0 is treated as 1.
REQ-023 ID FIFO full: reads are not granted (h_waitrequest stays high); writes are still granted.
REQ-024 m_readdatavalid routes to h_readdatavalid[head id]; each beat decrements the head count; at the last beat, pop the head.
REQ-025 A FIFO push and pop in the same cycle keeps occupancy unchanged.
REQ-026 m_readdatavalid with an empty FIFO: drop the beat and set err_orphan.
REQ-027 Round-robin pointer wraps from N_HOSTS-1 to 0.

Reset
REQ-028 Reset values: FSM = IDLE, FIFO empty, round-robin pointer = N_HOSTS-1, all h_waitrequest = 1, m_read = m_write = 0, h_readdatavalid = 0, err_orphan = 0.
REQ-029 Reset mid-burst or with reads outstanding abandons all state immediately; nothing is replayed.

Configuration
REQ-030 With AVMM_ARB_FIXED_PRIO_EN defined, arbitration is fixed priority (lowest index wins) and the pointer is unused; without it, arbitration is round-robin per REQ-017.

Structure
REQ-031 arb_state_e and the ID FIFO entry struct belong in avmm_lvds_bridge_pkg, reusing ADDR_W, burstcnt_t and MAX_BURST.
REQ-032 The ID FIFO is a sub-module, avmm_arb_id_fifo (synchronous, with full/empty outputs).

Verification
REQ-033 Hosts 0 and 1 both issue single writes continuously -> m_write alternates hosts 0,1,0,1; each host gets 1 grant per 2 commands.
REQ-034 Host 0 writes a burstcount=16 burst while host 1 requests -> host 1 waits until all 16 beats are accepted, then is granted next.
REQ-035 Host 1 reads a 4-beat burst, host 0 reads 1 beat; bridge returns 5 beats -> h_readdatavalid[1] ×4, then h_readdatavalid[0] ×1.
REQ-036 Issue 8 reads with no response, then a 9th read -> h_waitrequest stays high until the first response completes; a concurrent write is still granted.
REQ-037 m_readdatavalid with no read outstanding -> err_orphan = 1 until reset; assert rst_n low mid-burst -> all outputs at their REQ-028 values.
